// File: rtl/axis_tbcall_pkg.sv
// Shared types for the testbench-call arbiter.
// Holds the arbiter FSM encoding and the source-count ceiling.
package axis_tbcall_pkg;

    localparam int TBCALL_MAX_REQ = 16;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        STOP,
        CALL,
        DONE
    } tbcall_state_e;

endpackage

// File: rtl/axis_tbcall_arb_if.sv
// Host-side call channel: clock-stop request/ack and call handshake.
// master = arbiter, slave = host / stop logic.
interface axis_tbcall_arb_if #(
    parameter int ID_W = 2
) ();

    logic            stop_req;
    logic            stopped;
    logic            call_valid;
    logic [ID_W-1:0] call_id;
    logic            call_ack;

    modport master (
        output stop_req,
        output call_valid,
        output call_id,
        input  stopped,
        input  call_ack
    );

    modport slave (
        input  stop_req,
        input  call_valid,
        input  call_id,
        output stopped,
        output call_ack
    );

endinterface

// File: rtl/axis_tbcall_rr_pick.sv
// Combinational round-robin pick: lowest pending index at or above
// the pointer, wrapping back to 0.
module axis_tbcall_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] pending_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    int j;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!any_o && pending_i[j]) begin
                any_o = 1'b1;
                idx_o = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/axis_tbcall_arb.sv
// Arbitrates per-site tbcall sources onto the single host call channel,
// stopping emulation clocks around each call.
module axis_tbcall_arb
    import axis_tbcall_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             pui,
    axis_tbcall_arb_if.master host,
    output logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] pending,
    output logic             busy,
    output logic             err_tmo
);

    tbcall_state_e    state_q, state_d;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] set, clr;
    logic [ID_W-1:0]  call_id_q, call_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;

    axis_tbcall_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .pending_i (pending_q),
        .ptr_i     (rr_ptr_q),
        .idx_o     (pick_idx),
        .any_o     (pick_any)
    );

    assign set = req & ~req_q & {N_REQ{~pui}};

    always_comb begin
        state_d   = state_q;
        call_id_d = call_id_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_d     = '0;
        err_d     = err_q;
        clr       = '0;
        unique case (state_q)
            IDLE: if (pick_any) state_d = GRANT;
            GRANT: begin
                call_id_d = pick_idx;
                clr       = N_REQ'(1) << pick_idx;
                state_d   = STOP;
            end
            STOP: if (host.stopped) state_d = CALL;
            CALL: begin
                tmo_d = tmo_q + 1'b1;
                if (host.call_ack) begin
                    state_d = DONE;
                end else if (&tmo_q) begin
                    // abandoned call: flag it and release the clocks
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (int'(call_id_q) == N_REQ - 1) rr_ptr_d = '0;
                else rr_ptr_d = call_id_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a new edge wins over the grant clear
        pending_d = (pending_q & ~clr) | set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= req;
            pending_q <= '0;
            call_id_q <= '0;
            rr_ptr_q  <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pending_q <= pending_d;
            call_id_q <= call_id_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign host.stop_req   = (state_q == STOP) || (state_q == CALL);
    assign host.call_valid = (state_q == CALL);
    assign host.call_id    = call_id_q;
    assign done    = (state_q == DONE) ? (N_REQ'(1) << call_id_q) : '0;
    assign pending = pending_q;
    assign busy    = (state_q != IDLE);
    assign err_tmo = err_q;

endmodule

// File: tb/tb_axis_tbcall_arb.sv
// Directed bench for axis_tbcall_arb (N_REQ=4, ID_W=2, TMO_W=4).
module tb_axis_tbcall_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       pui;
    logic [3:0] done;
    logic [3:0] pending;
    logic       busy;
    logic       err_tmo;
    int         tests = 0;
    int         fails = 0;
    int         bad;
    int         n;

    axis_tbcall_arb_if #(.ID_W(2)) hif ();

    axis_tbcall_arb #(
        .N_REQ (4),
        .ID_W  (2),
        .TMO_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .pui     (pui),
        .host    (hif.master),
        .done    (done),
        .pending (pending),
        .busy    (busy),
        .err_tmo (err_tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cv();
        n = 0;
        while (hif.call_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("wait_call_valid", 32'(hif.call_valid), 32'd1);
    endtask

    task automatic serve(input logic [1:0] id);
        wait_cv();
        chk("svc_call_id", 32'(hif.call_id), 32'(id));
        hif.call_ack = 1'b1;
        tick();
        hif.call_ack = 1'b0;
        chk("svc_done", 32'(done), 32'(4'b0001 << id));
        tick();
        chk("svc_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0010;
        pui = 1'b0;
        hif.stopped  = 1'b0;
        hif.call_ack = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_stop_req", 32'(hif.stop_req), 32'd0);
        chk("rst_call_valid", 32'(hif.call_valid), 32'd0);
        chk("rst_err", 32'(err_tmo), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // held-high request must not fire after reset
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hif.stop_req !== 1'b0 || pending !== 4'b0) bad++;
        end
        chk("held_req_quiet", 32'(bad), 32'd0);
        req = 4'b0000;
        tick();

        // single call on source 2, ack three cycles in
        hif.stopped = 1'b1;
        req = 4'b0100;
        tick();
        chk("t2_pending", 32'(pending), 32'h4);
        chk("t2_stop_e1", 32'(hif.stop_req), 32'd0);
        tick();
        chk("t2_busy_grant", 32'(busy), 32'd1);
        chk("t2_stop_e2", 32'(hif.stop_req), 32'd0);
        req = 4'b0000;
        tick();
        chk("t2_stop_e3", 32'(hif.stop_req), 32'd1);
        chk("t2_call_id", 32'(hif.call_id), 32'd2);
        chk("t2_pend_clr", 32'(pending), 32'd0);
        chk("t2_cv_stop", 32'(hif.call_valid), 32'd0);
        tick();
        chk("t2_cv", 32'(hif.call_valid), 32'd1);
        tick();
        tick();
        hif.call_ack = 1'b1;
        tick();
        hif.call_ack = 1'b0;
        chk("t2_done", 32'(done), 32'h4);
        chk("t2_cv_done", 32'(hif.call_valid), 32'd0);
        chk("t2_stop_done", 32'(hif.stop_req), 32'd0);
        tick();
        chk("t2_done_1cyc", 32'(done), 32'd0);
        chk("t2_busy_fall", 32'(busy), 32'd0);

        // round-robin: pointer back to 0, three simultaneous edges
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1011;
        tick();
        chk("t3_pending", 32'(pending), 32'hb);
        req = 4'b0000;
        serve(2'd0);
        req = 4'b0001;
        serve(2'd1);
        serve(2'd3);
        serve(2'd0);
        req = 4'b0000;
        tick();

        // stop acknowledge held off for 50 cycles
        hif.stopped = 1'b0;
        req = 4'b0010;
        n = 0;
        while (hif.stop_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_stop_req", 32'(hif.stop_req), 32'd1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (hif.stop_req !== 1'b1 || hif.call_valid !== 1'b0) bad++;
        end
        chk("t4_held_stop", 32'(bad), 32'd0);
        hif.stopped = 1'b1;
        tick();
        chk("t4_cv", 32'(hif.call_valid), 32'd1);
        chk("t4_call_id", 32'(hif.call_id), 32'd1);
        hif.stopped = 1'b0;
        tick();
        chk("t4_stopped_drop", 32'({hif.stop_req, hif.call_valid}), 32'd3);
        hif.call_ack = 1'b1;
        tick();
        hif.call_ack = 1'b0;
        chk("t4_done", 32'(done), 32'h2);
        hif.stopped = 1'b1;
        req = 4'b0000;
        tick();

        // host never acks: 16 CALL cycles then timeout
        req = 4'b0100;
        wait_cv();
        req = 4'b0000;
        repeat (15) tick();
        chk("t5_cv_c16", 32'(hif.call_valid), 32'd1);
        chk("t5_err_pre", 32'(err_tmo), 32'd0);
        tick();
        chk("t5_err_set", 32'(err_tmo), 32'd1);
        chk("t5_done", 32'(done), 32'h4);
        tick();
        hif.call_ack = 1'b1;
        tick();
        hif.call_ack = 1'b0;
        chk("t5_stray_ack", 32'({busy, done}), 32'd0);
        repeat (5) tick();
        chk("t5_err_sticky", 32'(err_tmo), 32'd1);

        // reset in the middle of a call, with pui masking edges
        req = 4'b0001;
        wait_cv();
        req = 4'b1001;
        tick();
        chk("t6_pending", 32'(pending), 32'h8);
        chk("t6_in_call", 32'(hif.call_valid), 32'd1);
        rst = 1'b1;
        pui = 1'b1;
        req = 4'b1101;
        tick();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pend_clr", 32'(pending), 32'd0);
        chk("t6_cv", 32'(hif.call_valid), 32'd0);
        chk("t6_err_clr", 32'(err_tmo), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("t6_pui_mask", 32'(pending), 32'd0);
        pui = 1'b0;
        tick();
        tick();
        chk("t6_quiet", 32'({busy, pending}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
